pwr_island_seq: RTL

//  Power-down/up sequencer for one switchable voltage island whose outputs reach the always-on domain via level shifters.

---
 rtl/pwr_seq_pkg.sv | 101 ++++++++++
 rtl/pwr_seq_timer.sv | 34 +++
 rtl/pwr_island_seq.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pwr_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pwr_seq_pkg
//  Brief    : Shared types, defaults and the per-state output map for the
//             switchable-island power sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package pwr_seq_pkg;

    localparam int unsigned DEF_SETTLE_CYC  = 4;
    localparam int unsigned DEF_ACK_TIMEOUT = 255;
    localparam int unsigned DEF_CNT_W       = 8;

    // ON and DEISO keep their fixed encodings; OFF sits after the power-up path.
    typedef enum logic [3:0] {
        ST_ON      = 4'd0,
        ST_ISO     = 4'd1,
        ST_SAVE    = 4'd2,
        ST_RST     = 4'd3,
        ST_SW_OFF  = 4'd4,
        ST_SW_ON   = 4'd5,
        ST_SETTLE  = 4'd6,
        ST_RST_REL = 4'd7,
        ST_RESTORE = 4'd8,
        ST_DEISO   = 4'd9,
        ST_OFF     = 4'd10
    } pwr_state_e;

    typedef struct packed {
        logic pd_ack;
        logic pwr_sw_en;
        logic iso_en;
        logic ret_save;
        logic ret_restore;
        logic island_rst_n;
    } pwr_outs_t;

    // Output levels of the fully powered, released island (also the reset values).
    localparam pwr_outs_t OUTS_ON = '{
        pd_ack:       1'b0,
        pwr_sw_en:    1'b1,
        iso_en:       1'b0,
        ret_save:     1'b0,
        ret_restore:  1'b0,
        island_rst_n: 1'b1
    };

    // Output levels while resident in a given state. Registered against the
    // next state so that outputs change on the same edge as the state.
    function automatic pwr_outs_t state_outputs(input pwr_state_e s);
        pwr_outs_t o;
        o = OUTS_ON;
        case (s)
            ST_ISO: begin
                o.iso_en = 1'b1;
            end
            ST_SAVE: begin
                o.iso_en   = 1'b1;
                o.ret_save = 1'b1;
            end
            ST_RST: begin
                o.iso_en       = 1'b1;
                o.island_rst_n = 1'b0;
            end
            ST_SW_OFF: begin
                o.iso_en       = 1'b1;
                o.island_rst_n = 1'b0;
                o.pwr_sw_en    = 1'b0;
            end
            ST_OFF: begin
                o.pd_ack       = 1'b1;
                o.iso_en       = 1'b1;
                o.island_rst_n = 1'b0;
                o.pwr_sw_en    = 1'b0;
            end
            ST_SW_ON, ST_SETTLE: begin
                o.pd_ack       = 1'b1;
                o.iso_en       = 1'b1;
                o.island_rst_n = 1'b0;
            end
            ST_RST_REL: begin
                o.pd_ack = 1'b1;
                o.iso_en = 1'b1;
            end
            ST_RESTORE: begin
                o.pd_ack      = 1'b1;
                o.iso_en      = 1'b1;
                o.ret_restore = 1'b1;
            end
            ST_DEISO: begin
                o.pd_ack = 1'b1;
            end
            default: begin
                o = OUTS_ON;
            end
        endcase
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwr_seq_timer.sv
`default_nettype none
// ============================================================================
//  Module   : pwr_seq_timer
//  Brief    : Loadable down-counter that saturates at zero, with a zero flag.
//             Shared between settle holds and switch-ack timeout.
//  Revision : 1.0  initial release
// ============================================================================
module pwr_seq_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load wins; otherwise count down and stick at zero (never wraps).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule
`default_nettype wire

// File: rtl/pwr_island_seq.sv
`default_nettype none
// ============================================================================
//  Module   : pwr_island_seq
//  Brief    : Always-on power sequencer for one switchable island: orders
//             isolation, retention save/restore, island reset and the header
//             switch behind a 4-phase req/ack handshake.
//  Revision : 1.0  initial release
// ============================================================================
module pwr_island_seq
    import pwr_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pd_req_i,
    output logic       pd_ack_o,
    output logic       pwr_sw_en_o,
    input  logic       pwr_sw_ack_i,
    output logic       iso_en_o,
    output logic       ret_save_o,
    output logic       ret_restore_o,
    output logic       island_rst_no,
    input  logic       err_clr_i,
    output logic       err_o,
    output logic [3:0] state_o
);

    // The counter is loaded with N-1 so a state is occupied for exactly N cycles.
    localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(ACK_TIMEOUT - 1);

    pwr_state_e       state;
    pwr_state_e       state_next;
    pwr_outs_t        outs;
    logic             err;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_zero;
    logic             ack_wait;

    pwr_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .zero     (tmr_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ON;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and timer load on every state entry.
    always_comb begin
        state_next   = state;
        tmr_load_val = '0;
        case (state)
            ST_ON:      if (pd_req_i)      state_next = ST_ISO;
            ST_ISO:     if (tmr_zero)      state_next = ST_SAVE;
            ST_SAVE:                       state_next = ST_RST;
            ST_RST:                        state_next = ST_SW_OFF;
            ST_SW_OFF:  if (!pwr_sw_ack_i) state_next = ST_OFF;
            ST_OFF:     if (!pd_req_i)     state_next = ST_SW_ON;
            ST_SW_ON:   if (pwr_sw_ack_i)  state_next = ST_SETTLE;
            ST_SETTLE:  if (tmr_zero)      state_next = ST_RST_REL;
            ST_RST_REL:                    state_next = ST_RESTORE;
            ST_RESTORE:                    state_next = ST_DEISO;
            ST_DEISO:   if (tmr_zero)      state_next = ST_ON;
            default:                       state_next = ST_ON;
        endcase
        case (state_next)
            ST_ISO, ST_SETTLE, ST_DEISO: tmr_load_val = SETTLE_LD;
            ST_SW_OFF, ST_SW_ON:         tmr_load_val = TIMEOUT_LD;
            default:                     tmr_load_val = '0;
        endcase
    end

    assign tmr_load = (state_next != state);

    // Still waiting for the rail to reach the commanded level.
    assign ack_wait = ((state == ST_SW_OFF) &&  pwr_sw_ack_i) ||
                      ((state == ST_SW_ON)  && !pwr_sw_ack_i);

    // Output registers follow the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outs <= OUTS_ON;
        end else begin
            outs <= state_outputs(state_next);
        end
    end

    // Sticky timeout flag; clear has priority over a concurrent set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (err_clr_i) begin
            err <= 1'b0;
        end else if (ack_wait && tmr_zero) begin
            err <= 1'b1;
        end
    end

    assign pd_ack_o      = outs.pd_ack;
    assign pwr_sw_en_o   = outs.pwr_sw_en;
    assign iso_en_o      = outs.iso_en;
    assign ret_save_o    = outs.ret_save;
    assign ret_restore_o = outs.ret_restore;
    assign island_rst_no = outs.island_rst_n;
    assign err_o         = err;
    assign state_o       = state;

endmodule
`default_nettype wire
